md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the HI and LO architectural registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency and reports busy to the hazard unit.
- Services mthi/mtlo writes.
- Its hi/lo outputs feed the writeback data mux (through the pipeline registers for mfhi/mflo).

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous active-low reset
- A  in  32  operand rs (dividend / multiplicand; mthi/mtlo data)
- B  in  32  operand rt (divisor / multiplier)
- start  in  1  launch operation selected by md_op this cycle
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
- mthi  in  1  write A to HI
- mtlo  in  1  write A to LO
- flush  in  1  exception/interrupt cancel of the EX-stage instruction
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, any pending result discarded. Reset asserted mid-operation aborts it; after release the unit is idle.
- State: IDLE / RUN with a down-counter.
- Launch:
  - At a rising edge with start=1, flush=0 and busy=0: latch A, B and md_op. Enter RUN, busy=1, counter=N (MULT_CYCLES or DIV_CYCLES).
  - Each following edge in RUN decrements the counter. On the edge where the counter goes 1->0, hi/lo take the result and busy returns to 0 on that same edge.
  - busy is high for exactly N cycles after the launch edge. The new hi/lo are visible in the first cycle busy is 0.
- start while busy=1: ignored. The hazard unit stalls on start|busy, so this is not expected; if it occurs, state is unchanged.
- start with flush=1 in the same cycle: ignored (instruction cancelled).
- flush during RUN: does not cancel; the operation is already committed.
- mthi/mtlo:
  - Accepted only when busy=0, flush=0 and start=0.
  - At the edge, hi<=A (mthi) and/or lo<=A (mtlo). Both asserted writes both.
  - Ignored while busy.
  - If start is also asserted, start has priority.
- mult: {hi,lo} = signed(A)*signed(B), 64-bit. multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Special case: A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: lo = A/B, hi = A%B, unsigned.
- B=0 for div/divu: full latency and busy sequence still occurs; hi and lo are left unchanged at completion.
- Result may be computed at launch into shadow registers or iteratively. Only commit timing and the final values are architectural.
- Back-to-back: start may be accepted in the cycle busy first reads 0. That cycle's hi/lo already hold the previous result.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3, start pulse -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 -> lo=3, hi=1. div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> hi/lo hold those values. Divide by zero (B=0) -> busy 10 cycles, hi/lo still 0x12345678 / 0x9ABCDEF0.
- During busy: assert start (md_op=mult, different operands) and mthi -> both ignored; first operation's result commits on schedule. start with flush=1 -> busy stays 0, hi/lo unchanged.
- Launch div, flush at cycle 3 -> result still commits at cycle 10. Launch mult, drop reset at cycle 2 -> hi=lo=0 and busy=0 immediately (asynchronous); no later commit after reset release.
- Back-to-back: new start in the first cycle busy=0 -> accepted; busy re-asserts on that edge.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div with a fixed
// latency, and reports busy to the hazard unit while an operation is in flight.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   a_reg, b_reg;
  logic [1:0]    op_reg;
  logic [31:0]   hi_reg, lo_reg;

  // Result is derived from the operands latched at launch; it only matters on
  // the commit edge, so a single combinational datapath is shared by all ops.
  logic        signed_op;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    signed_op = ~op_reg[0];
    a_ext     = {{32{signed_op & a_reg[31]}}, a_reg};
    b_ext     = {{32{signed_op & b_reg[31]}}, b_reg};
    prod      = a_ext * b_ext;

    // Sign-magnitude division: the 0x80000000 / -1 case falls out naturally.
    a_neg = signed_op & a_reg[31];
    b_neg = signed_op & b_reg[31];
    a_mag = a_neg ? (~a_reg + 32'd1) : a_reg;
    b_mag = b_neg ? (~b_reg + 32'd1) : b_reg;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !flush) begin
            a_reg     <= A;
            b_reg     <= B;
            op_reg    <= md_op;
            count_reg <= md_op[1] ? DIV_N : MULT_N;
            state_reg <= ST_RUN;
          end else if (!start && !flush) begin
            if (mthi) hi_reg <= A;
            if (mtlo) lo_reg <= A;
          end
        end
        default: begin
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= ST_IDLE;
            if (!op_reg[1]) begin
              hi_reg <= prod[63:32];
              lo_reg <= prod[31:0];
            end else if (b_reg != 32'd0) begin
              hi_reg <= rem;
              lo_reg <= quo;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        start = 1'b0;
  logic [1:0]  md_op = '0;
  logic        mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .start(start), .md_op(md_op),
    .mthi(mthi), .mtlo(mtlo), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: absolute cycle count and the cycle on which a result lands.
  longint      cyc = 0;
  longint      done_cyc = 0;
  bit          pend = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic void compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output bit ok);
    longint          p, q, r;
    longint unsigned pu;
    ok = 1'b1;
    rh = '0;
    rl = '0;
    case (op)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {rh, rl} = p;
      end
      2'd1: begin
        pu = a;
        pu = pu * b;
        {rh, rl} = pu;
      end
      2'd2: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    bit ok;
    was_busy = (cyc < done_cyc);
    cyc = cyc + 1;
    if (reset) begin
      if (was_busy) begin
        if (cyc == done_cyc && pend) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (start && !flush) begin
        compute(md_op, A, B, p_hi, p_lo, ok);
        pend = ok;
        done_cyc = cyc + (md_op[1] ? DIV_N : MULT_N);
      end else if (!start && !flush) begin
        if (mthi) m_hi = A;
        if (mtlo) m_lo = A;
      end
    end
  end

  always @(negedge reset) begin
    done_cyc = 0;
    pend = 1'b0;
    m_hi = '0;
    m_lo = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (cyc < done_cyc)});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    step();
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    $display("launch op=%0d A=%h B=%h busy=%0b", op, a, b, busy);
  endtask

  // Count busy cycles after a launch, optionally flushing or disturbing mid-run.
  task automatic run_busy(input string name, input int exp_n, input int flush_at, input bit disturb);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      flush = (n == flush_at);
      if (disturb && n < 2) begin
        start = 1'b1;
        md_op = 2'd0;
        A = 32'hDEAD_BEEF;
        B = 32'h0000_0077;
        mthi = 1'b1;
      end else begin
        start = 1'b0;
        mthi = 1'b0;
      end
      step();
      n++;
    end
    flush = 1'b0;
    start = 1'b0;
    mthi = 1'b0;
    check(name, 32'(n), 32'(exp_n));
    $display("%s: busy cycles=%0d hi=%h lo=%h", name, n, hi, lo);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    step();

    launch(2'd0, 32'hFFFF_FFFE, 32'd3);
    run_busy("mult_lat", MULT_N, -1, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    launch(2'd1, 32'hFFFF_FFFE, 32'd3);
    run_busy("multu_lat", MULT_N, -1, 1'b0);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_busy("div_lat", DIV_N, -1, 1'b0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    launch(2'd3, 32'd7, 32'd2);
    run_busy("divu_lat", DIV_N, -1, 1'b0);
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);

    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("divovf_lat", DIV_N, -1, 1'b0);
    check("divovf_hi", hi, 32'd0);
    check("divovf_lo", lo, 32'h8000_0000);

    mthi = 1'b1; A = 32'h1234_5678; step(); mthi = 1'b0;
    mtlo = 1'b1; A = 32'h9ABC_DEF0; step(); mtlo = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);

    launch(2'd2, 32'd55, 32'd0);
    run_busy("div0_lat", DIV_N, -1, 1'b0);
    check("div0_hi", hi, 32'h1234_5678);
    check("div0_lo", lo, 32'h9ABC_DEF0);

    launch(2'd1, 32'd5, 32'd7);
    run_busy("disturb_lat", MULT_N, -1, 1'b1);
    check("disturb_hi", hi, 32'd0);
    check("disturb_lo", lo, 32'd35);

    start = 1'b1; flush = 1'b1; mthi = 1'b1; A = 32'h5555_AAAA; step();
    start = 1'b0; flush = 1'b0; mthi = 1'b0;
    check("flushstart_busy", {31'd0, busy}, 32'd0);
    check("flushstart_hi", hi, 32'd0);
    check("flushstart_lo", lo, 32'd35);

    launch(2'd3, 32'd100, 32'd7);
    run_busy("flushrun_lat", DIV_N, 2, 1'b0);
    check("flushrun_hi", hi, 32'd2);
    check("flushrun_lo", lo, 32'd14);

    launch(2'd0, 32'd1000, 32'd1000);
    step();
    reset = 1'b0;
    #2;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    repeat (8) step();
    check("arst_post_busy", {31'd0, busy}, 32'd0);
    check("arst_post_lo", lo, 32'd0);

    launch(2'd1, 32'd2, 32'd3);
    run_busy("b2b1_lat", MULT_N, -1, 1'b0);
    check("b2b_prev_lo", lo, 32'd6);
    launch(2'd1, 32'd4, 32'd5);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    run_busy("b2b2_lat", MULT_N, -1, 1'b0);
    check("b2b_lo", lo, 32'd20);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        $display("rand %0d: reset pulse", i);
      end
      start = ($urandom_range(0, 3) == 0);
      md_op = 2'($urandom_range(0, 3));
      A     = pick32();
      B     = pick32();
      mthi  = ($urandom_range(0, 6) == 0);
      mtlo  = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
      if (start && !flush)
        $display("rand %0d: start op=%0d A=%h B=%h busy=%0b hi=%h lo=%h", i, md_op, A, B, busy, hi, lo);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    repeat (DIV_N + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
